regfile_write_arbiter: RTL

//  Shares the register file's single write port (writeS/address3/writeData) between two writers.

---
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between two writers.
//   Requester 0 is the pipeline writeback stage. It has priority and can only be stalled.
//   Requester 1 is a multi-cycle unit that uses a valid/ready handshake.
//   A starvation counter forces a grant to requester 1 after MAX_WAIT refused cycles.
//   The write command to the register file is registered, so it appears one cycle after the grant.
//
// Ports
//   clk, rst                          clock and asynchronous active-high reset
//   req0_valid/addr/data -> stall0    writeback request; stall0 means "hold req0_* stable"
//   req1_valid/addr/data -> req1_ready  unit-1 request; the handshake is valid & ready
//   writeS/address3/writeData         registered register-file write command
//   force_count                       number of forced grants (saturating)
module regfile_write_arbiter #(
    parameter int MAX_WAIT     = 4,
    parameter bit ZERO_PROTECT = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [4:0]       req0_addr,
    input  logic [31:0]      req0_data,
    output logic             stall0,
    input  logic             req1_valid,
    input  logic [4:0]       req1_addr,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    output logic             writeS,
    output logic [4:0]       address3,
    output logic [31:0]      writeData,
    output logic [CNT_W-1:0] force_count
);

    localparam int                WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]     WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] force_count_q, force_count_d;
    logic             writeS_q, writeS_d;
    logic [4:0]       address3_q, address3_d;
    logic [31:0]      writeData_q, writeData_d;

    logic             force_w;
    logic             grant0, grant1;
    logic [4:0]       g_addr;
    logic [31:0]      g_data;

    // Grant decision. Requester 1 wins when it is forced or when requester 0 is idle.
    always_comb begin
        force_w = req1_valid & (wait_cnt_q == WAIT_MAX);
        grant1  = req1_valid & (force_w | ~req0_valid);
        grant0  = req0_valid & ~grant1;
        g_addr  = grant1 ? req1_addr : req0_addr;
        g_data  = grant1 ? req1_data : req0_data;
    end

    // The handshake outputs are gated by reset so that nothing is accepted while the port is down.
    assign stall0     = ~rst & req0_valid & grant1;
    assign req1_ready = ~rst & grant1;

    always_comb begin
        // Count refused cycles only while req1 is pending.
        // Any handshake or withdrawal of the request restarts the count from 0.
        wait_cnt_d = wait_cnt_q;
        if (!req1_valid || grant1)
            wait_cnt_d = '0;
        else if (wait_cnt_q != WAIT_MAX)
            wait_cnt_d = wait_cnt_q + 1'b1;

        force_count_d = force_count_q;
        if (force_w && force_count_q != CNT_MAX)
            force_count_d = force_count_q + CNT_W'(1);

        // A granted write to r0 still consumes its slot and completes the handshake.
        // Only the enable is suppressed.
        writeS_d    = (grant0 | grant1) & ~(ZERO_PROTECT && g_addr == 5'd0);
        address3_d  = (grant0 | grant1) ? g_addr : address3_q;
        writeData_d = (grant0 | grant1) ? g_data : writeData_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            force_count_q <= '0;
            writeS_q      <= 1'b0;
            address3_q    <= '0;
            writeData_q   <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            force_count_q <= force_count_d;
            writeS_q      <= writeS_d;
            address3_q    <= address3_d;
            writeData_q   <= writeData_d;
        end
    end

    assign writeS      = writeS_q;
    assign address3    = address3_q;
    assign writeData   = writeData_q;
    assign force_count = force_count_q;

endmodule
